// File: rtl/sample_frame_ctrl_if.sv
// sample_frame_ctrl_if: ADC capture controls, frame-buffer write port and frame handoff signals
interface sample_frame_ctrl_if #(parameter int AW = 8);
    logic        enable;
    logic [11:0] adc_sample;
    logic        wr_en;
    logic [AW:0] wr_addr;
    logic [15:0] wr_data;
    logic        frame_valid;
    logic        frame_bank;
    logic        frame_ack;
    logic [15:0] overrun_cnt;
    logic [1:0]  state_o;
    modport master (input enable, adc_sample, frame_ack,
                    output wr_en, wr_addr, wr_data, frame_valid, frame_bank, overrun_cnt, state_o);
    modport slave  (output enable, adc_sample, frame_ack,
                    input wr_en, wr_addr, wr_data, frame_valid, frame_bank, overrun_cnt, state_o);
endinterface

// File: rtl/sample_frame_ctrl.sv
// sample_frame_ctrl: ticks the ADC every DIV clocks and writes samples into a ping-pong frame buffer
module sample_frame_ctrl #(
    parameter int DIV       = 1000,
    parameter int FRAME_LEN = 256
) (
    input logic clk,
    input logic rst_n,
    sample_frame_ctrl_if.master bus
);
    localparam int AW = $clog2(FRAME_LEN);

    typedef enum logic [1:0] {IDLE = 2'd0, FILL = 2'd1, STALL = 2'd2} state_t;

    state_t        r_state, w_next;
    logic [15:0]   r_div;
    logic [AW-1:0] r_idx;
    logic          r_bank;
    logic [1:0]    r_full;
    logic          r_wr_en;
    logic [AW:0]   r_addr;
    logic [15:0]   r_data;
    logic [15:0]   r_ovr;
    logic          w_tick, w_write, w_done, w_ack, w_fbank;
    logic [1:0]    w_full_ack;

    assign w_tick     = bus.enable && r_div == 16'(DIV - 1);
    assign w_write    = w_tick && r_state == FILL;
    assign w_done     = w_write && r_idx == AW'(FRAME_LEN - 1);
    // with both banks full the one being waited on is the older frame
    assign w_fbank    = &r_full ? r_bank : r_full[1];
    assign w_ack      = bus.frame_ack && |r_full;
    assign w_full_ack = r_full & ~(w_ack ? (w_fbank ? 2'b10 : 2'b01) : 2'b00);

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;

    always_comb begin
        w_next = r_state;
        if (!bus.enable)                                      w_next = IDLE;
        else if (r_state == IDLE)                             w_next = FILL;
        else if (r_state == FILL && w_done && w_full_ack[~r_bank]) w_next = STALL;
        else if (r_state == STALL && !r_full[r_bank])         w_next = FILL;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div   <= '0;
            r_idx   <= '0;
            r_bank  <= 1'b0;
            r_full  <= 2'b00;
            r_wr_en <= 1'b0;
            r_addr  <= '0;
            r_data  <= '0;
            r_ovr   <= '0;
        end else begin
            r_div   <= (!bus.enable || w_tick) ? 16'd0 : r_div + 16'd1;
            r_wr_en <= w_write;
            if (w_write) begin
                r_addr <= {r_bank, r_idx};
                r_data <= {~bus.adc_sample[11], bus.adc_sample[10:0], 4'b0000};
            end
            r_idx   <= !bus.enable ? '0 : w_write ? r_idx + AW'(1) : r_idx;
            r_bank  <= r_bank ^ w_done;
            r_full  <= w_full_ack | (w_done ? (r_bank ? 2'b10 : 2'b01) : 2'b00);
            if (r_state == STALL && w_tick && r_ovr != 16'hFFFF) r_ovr <= r_ovr + 16'd1;
        end
    end

    assign bus.wr_en       = r_wr_en;
    assign bus.wr_addr     = r_addr;
    assign bus.wr_data     = r_data;
    assign bus.frame_valid = |r_full;
    assign bus.frame_bank  = w_fbank;
    assign bus.overrun_cnt = r_ovr;
    assign bus.state_o     = r_state;
endmodule

// File: doc/sample_frame_ctrl.md
SAMPLE_FRAME_CTRL -- requirements
Module: sample_frame_ctrl

Interface
REQ-001 Parameter DIV, default 1000: clk cycles per audio sample, legal 2..65535.
REQ-002 Parameter FRAME_LEN, default 256: samples per frame, power of two, legal 4..1024.
REQ-003 Port clk  input  1: single clock for all logic.
REQ-004 Port rst_n  input  1: reset, asynchronous assert, active-low.
REQ-005 Port enable  input  1: capture enable, level-sensitive.
REQ-006 Port adc_sample  input  12: free-running ADC CH0 result, offset-binary, stable between ticks.
REQ-007 Port wr_en  output  1: one-cycle frame-buffer write strobe.
REQ-008 Port wr_addr  output  log2(FRAME_LEN)+1: {bank, index}; bank is the MSB.
REQ-009 Port wr_data  output  16: signed, left-justified sample.
REQ-010 Port frame_valid  output  1: a completed frame is waiting for the consumer.
REQ-011 Port frame_bank  output  1: bank holding the offered frame; meaningful only while frame_valid=1.
REQ-012 Port frame_ack  input  1: one-cycle pulse; consumer has finished the offered frame.
REQ-013 Port overrun_cnt  output  16: count of samples dropped due to both banks full, saturating.
REQ-014 Port state_o  output  2: current state encoding, IDLE=0, FILL=1, STALL=2.

Function
REQ-015 The divider counter SHALL count 0..DIV-1 while enable=1, SHALL hold at 0 while enable=0, and SHALL raise an internal tick in the cycle where it equals DIV-1.
REQ-016 On a tick in FILL, the block SHALL register adc_sample and drive wr_en=1 in the next cycle only (latency 1 cycle).
REQ-017 During that strobe, wr_data SHALL equal {~adc_sample[11], adc_sample[10:0], 4'b0000}; for example, 12'h800 maps to 16'h0000, 12'hFFF to 16'h7FF0, and 12'h000 to 16'h8000.
REQ-018 During that strobe, wr_addr SHALL equal {wr_bank, idx}; idx SHALL then increment, wrapping from FRAME_LEN-1 to 0.
REQ-019 The write at idx=FRAME_LEN-1 SHALL set full[wr_bank] and toggle wr_bank in the same cycle as the strobe.
REQ-020 Full banks SHALL be offered in completion order: frame_valid=1 whenever any full flag is set, with frame_bank pointing at the oldest full bank.
REQ-021 frame_ack while frame_valid=1 SHALL clear full[frame_bank] on the next edge; frame_ack while frame_valid=0 SHALL be ignored.
REQ-022 States and transitions:
- IDLE -> FILL when enable=1.
- FILL -> STALL when the frame completes and full[new wr_bank] is already set.
- STALL -> FILL on the cycle after full[wr_bank] clears, with idx=0.
- Any state -> IDLE when enable=0.
REQ-023 In STALL, each tick SHALL increment overrun_cnt, saturating at 16'hFFFF; no writes occur.
REQ-024 A frame_ack and a frame completion in the same cycle SHALL be resolved ack-first, so the block stays in FILL if the ack frees the next bank.
REQ-025 Deasserting enable mid-frame SHALL discard the partial frame: idx returns to 0, wr_bank and full flags are kept, and any pending wr_en strobe still completes.
REQ-026 After a tick, the next tick SHALL follow exactly DIV cycles later while enable remains 1; there is no jitter across frame or stall boundaries.

Reset
REQ-027 While rst_n=0, the block SHALL hold: state IDLE, divider 0, idx 0, wr_bank 0, full flags 00, wr_en 0, wr_addr 0, wr_data 0, frame_valid 0, frame_bank 0, overrun_cnt 0.
REQ-028 Release of rst_n SHALL take effect on the first clk edge after release; the first tick SHALL occur DIV cycles after enable is sampled high.

Verification (DIV=4, FRAME_LEN=8)
REQ-029 Sample conversion: hold adc_sample=12'hA5C with enable=1 -> wr_en pulses every 4 cycles, wr_data=16'h25C0, wr_addr=0,1,...,7.
REQ-030 Frame handoff: run 8 ticks -> after the 8th strobe, frame_valid=1 and frame_bank=0; the next write goes to wr_addr=4'h8.
REQ-031 Overrun: run 16 ticks with no ack, then 3 more ticks -> state_o=2, overrun_cnt=3, no wr_en; pulse frame_ack -> the bank-0 frame is released and FILL resumes at wr_addr=4'h0.
REQ-032 Simultaneous events: with bank 1 full, fire frame_ack in the same cycle as the last bank-0 write -> no STALL, frame_valid stays 1, frame_bank moves from 1 to 0.
REQ-033 Abort: drop enable after 5 writes, then re-raise it -> the next write goes to wr_addr=4'h0, and full flags are unchanged.
REQ-034 Reset mid-frame: assert rst_n=0 asynchronously between edges -> all outputs are 0 immediately, and a spurious frame_ack after release is ignored.
